// File: rtl/fpu_pkg.sv
// Shared FPU types: single-precision word, reciprocal result bundle and constants.
package fpu_pkg;
  typedef logic [31:0] fp32_t;

  typedef struct packed {
    fp32_t y;
    logic  ovf;
    logic  udf;
  } finv_res_t;

  localparam fp32_t FP_ONE  = 32'h3F800000;
  localparam fp32_t FP_QNAN = 32'h7FC00000;
endpackage

// File: rtl/finv_arbiter_if.sv
// Request fan-in and tagged response channel between FPU issue logic and the shared finv.
interface finv_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  import fpu_pkg::*;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*32-1:0] req_x;
  logic [NREQ-1:0]    req_ready;
  logic               resp_valid;
  logic               resp_ready;
  logic [IDW-1:0]     resp_id;
  fp32_t              resp_y;
  logic               resp_ovf;
  logic               resp_udf;
  logic [31:0]        issue_cnt;

  modport master (
    output req_valid, req_x, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_y, resp_ovf, resp_udf, issue_cnt
  );

  modport slave (
    input  req_valid, req_x, resp_ready,
    output req_ready, resp_valid, resp_id, resp_y, resp_ovf, resp_udf, issue_cnt
  );
endinterface

// File: rtl/finv.sv
// Combinational single-precision reciprocal, truncated mantissa, denormals treated as zero.
module finv
  import fpu_pkg::*;
(
  input  fp32_t x,
  output fp32_t y,
  output logic  ovf,
  output logic  udf
);
  logic [23:0] m;
  logic [23:0] rem [25];
  logic [23:0] q;
  logic [9:0]  ee;
  logic        unused_bits;

  assign m      = {1'b1, x[22:0]};
  assign rem[0] = 24'h800000;

  // Restoring division of 2^47 by the 24-bit significand; q = floor(2^47 / m).
  genvar gi;
  for (gi = 0; gi < 24; gi++) begin : g_div
    logic [24:0] sh;
    logic [24:0] diff;
    assign sh          = {rem[gi], 1'b0};
    assign diff        = sh - {1'b0, m};
    assign q[23 - gi]  = ~diff[24];
    assign rem[gi + 1] = q[23 - gi] ? diff[23:0] : sh[23:0];
  end

  assign unused_bits = ^{rem[24], q[23]};

  // A non-unit significand puts 1/m in (0.5,1), costing one exponent step.
  assign ee = ((x[22:0] == 23'd0) ? 10'd254 : 10'd253) - {2'b00, x[30:23]};

  always_comb begin
    y   = '0;
    ovf = 1'b0;
    udf = 1'b0;
    if (x[30:23] == 8'hFF) begin
      y = (x[22:0] != 23'd0) ? FP_QNAN : {x[31], 31'd0};
    end else if (x[30:23] == 8'h00) begin
      y   = {x[31], 8'hFF, 23'd0};
      ovf = 1'b1;
    end else if (ee[9] || (ee == 10'd0)) begin
      y   = {x[31], 31'd0};
      udf = 1'b1;
    end else begin
      y = {x[31], ee[7:0], (x[22:0] == 23'd0) ? 23'd0 : q[22:0]};
    end
  end
endmodule

// File: rtl/rr_arbiter.sv
// Rotating-priority scan: first requester at or after ptr (mod N) wins when en is high.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic           en,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] gidx
);
  logic [N-1:0]   hit;
  logic [IDW-1:0] cand [N];

  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_scan
    assign cand[gi] = IDW'((int'(ptr) + gi) % N);
    assign hit[gi]  = req[cand[gi]];
  end

  // Walk offsets from the far end so the closest hit to ptr overrides the rest.
  always_comb begin
    grant = '0;
    gidx  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (hit[k]) gidx = cand[k];
    end
    if (en && (|hit)) grant[gidx] = 1'b1;
  end
endmodule

// File: rtl/finv_arbiter.sv
// Round-robin sharing of one finv among NREQ requesters through a two-stage pipe
// with a single tagged, backpressured response channel.
module finv_arbiter
  import fpu_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic           clk,
  input  logic           rst,
  finv_arbiter_if.slave  bus
);
  logic            adv;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gidx;
  fp32_t           req_x_arr [NREQ];

  logic [IDW-1:0]  rr_ptr_reg, rr_ptr_next;
  logic            s1_valid_reg;
  fp32_t           s1_x_reg;
  logic [IDW-1:0]  s1_id_reg;
  logic            resp_valid_reg;
  finv_res_t       resp_res_reg;
  logic [IDW-1:0]  resp_id_reg;
  logic [31:0]     issue_cnt_reg;

  fp32_t           fin_y;
  logic            fin_ovf, fin_udf;

  genvar gi;
  for (gi = 0; gi < NREQ; gi++) begin : g_slice
    assign req_x_arr[gi] = bus.req_x[32*gi +: 32];
  end

  // The whole pipe moves together; a stalled output freezes both stages.
  assign adv         = !resp_valid_reg || bus.resp_ready;
  assign rr_ptr_next = (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;

  rr_arbiter #(.N(NREQ), .IDW(IDW)) u_rr (
    .req   (bus.req_valid),
    .en    (adv),
    .ptr   (rr_ptr_reg),
    .grant (grant),
    .gidx  (gidx)
  );

  finv u_finv (
    .x   (s1_x_reg),
    .y   (fin_y),
    .ovf (fin_ovf),
    .udf (fin_udf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg     <= '0;
      s1_valid_reg   <= 1'b0;
      s1_x_reg       <= '0;
      s1_id_reg      <= '0;
      resp_valid_reg <= 1'b0;
      resp_res_reg   <= '0;
      resp_id_reg    <= '0;
      issue_cnt_reg  <= '0;
    end else if (adv) begin
      s1_valid_reg   <= |grant;
      resp_valid_reg <= s1_valid_reg;
      if (|grant) begin
        s1_x_reg      <= req_x_arr[gidx];
        s1_id_reg     <= gidx;
        rr_ptr_reg    <= rr_ptr_next;
        issue_cnt_reg <= issue_cnt_reg + 32'd1;
      end
      if (s1_valid_reg) begin
        resp_res_reg <= '{y: fin_y, ovf: fin_ovf, udf: fin_udf};
        resp_id_reg  <= s1_id_reg;
      end
    end
  end

  assign bus.req_ready  = grant;
  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_id    = resp_id_reg;
  assign bus.resp_y     = resp_res_reg.y;
  assign bus.resp_ovf   = resp_res_reg.ovf;
  assign bus.resp_udf   = resp_res_reg.udf;
  assign bus.issue_cnt  = issue_cnt_reg;
endmodule

// File: tb/tb_finv_arbiter.sv
// Randomized and directed bench for finv_arbiter against a queue-based reference model.
module tb_finv_arbiter;
  import fpu_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  finv_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus();
  finv_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int          n_vec = 0;
  int          n_err = 0;
  int          model_ptr;
  int unsigned model_cnt;
  fp32_t       sb_x [NREQ][$];
  int          sb_id [$];
  int          got_id [$];
  fp32_t       got_y [$];
  int          acc_log [$];

  logic            prev_hold;
  fp32_t           prev_y;
  logic [IDW-1:0]  prev_id;
  logic [1:0]      prev_flags;
  logic [NREQ-1:0] prev_wait;
  logic [NREQ*32-1:0] prev_x;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // 1/x from its definition: 2^(127-e) / (1.f), mantissa truncated.
  function automatic finv_res_t finv_ref(input fp32_t x);
    finv_res_t r;
    int        e, ee;
    longint    mfull, q;
    r = '0;
    e = int'(x[30:23]);
    if (e == 255) begin
      r.y = (x[22:0] != 0) ? 32'h7FC00000 : {x[31], 31'd0};
    end else if (e == 0) begin
      r.y   = {x[31], 8'hFF, 23'd0};
      r.ovf = 1'b1;
    end else begin
      mfull = longint'({1'b1, x[22:0]});
      if (x[22:0] == 0) begin
        ee = 254 - e;
        q  = mfull;
      end else begin
        ee = 253 - e;
        q  = (longint'(1) << 47) / mfull;
      end
      if (ee <= 0) begin
        r.y   = {x[31], 31'd0};
        r.udf = 1'b1;
      end else begin
        r.y = {x[31], 8'(ee), q[22:0]};
      end
    end
    return r;
  endfunction

  function automatic fp32_t rand_x();
    fp32_t v;
    v = $urandom();
    case ($urandom_range(0, 15))
      0: v[30:0]  = '0;
      1: v[30:23] = 8'h00;
      2: v[30:23] = 8'hFF;
      3: v[30:23] = 8'hFE;
      4: v[30:23] = 8'hFD;
      5: v[22:0]  = '0;
      6: v[30:0]  = 31'h7F800000;
      default: ;
    endcase
    return v;
  endfunction

  // One clock: check grant and output channel, update scoreboard, step the edge.
  task automatic cycle();
    logic [NREQ-1:0] exp_grant, acc;
    int              g, id;
    finv_res_t       er;
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (prev_wait[i] && bus.req_valid[i])
        assert (bus.req_x[32*i +: 32] == prev_x[32*i +: 32])
          else $error("requester %0d changed operand while waiting", i);
    end
    exp_grant = '0;
    if (!bus.resp_valid || bus.resp_ready) begin
      for (int k = 0; k < NREQ; k++) begin
        g = (model_ptr + k) % NREQ;
        if (bus.req_valid[g]) begin
          exp_grant[g] = 1'b1;
          break;
        end
      end
    end
    check("req_ready", bus.req_ready, exp_grant);
    check("issue_cnt", bus.issue_cnt, model_cnt);
    if (prev_hold) begin
      check("hold_valid", bus.resp_valid, 1);
      check("hold_y", bus.resp_y, prev_y);
      check("hold_id", bus.resp_id, prev_id);
      check("hold_flags", {bus.resp_ovf, bus.resp_udf}, prev_flags);
    end
    if (bus.resp_valid && bus.resp_ready) begin
      check("resp_pending", sb_id.size() != 0, 1);
      if (sb_id.size() != 0) begin
        id = sb_id.pop_front();
        check("resp_id", bus.resp_id, id);
        er = finv_ref(sb_x[id].pop_front());
        check("resp_y", bus.resp_y, er.y);
        check("resp_flags", {bus.resp_ovf, bus.resp_udf}, {er.ovf, er.udf});
        got_id.push_back(int'(bus.resp_id));
        got_y.push_back(bus.resp_y);
      end
    end
    acc = bus.req_valid & bus.req_ready;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) begin
        sb_x[i].push_back(bus.req_x[32*i +: 32]);
        sb_id.push_back(i);
        acc_log.push_back(i);
        model_ptr = (i + 1) % NREQ;
        model_cnt++;
      end
    end
    check("inflight_le2", sb_id.size() <= 2, 1);
    prev_hold  = bus.resp_valid && !bus.resp_ready;
    prev_y     = bus.resp_y;
    prev_id    = bus.resp_id;
    prev_flags = {bus.resp_ovf, bus.resp_udf};
    prev_wait  = bus.req_valid & ~acc;
    prev_x     = bus.req_x;
    @(posedge clk);
    #1;
    bus.req_valid = bus.req_valid & ~acc;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.req_valid  = '0;
    bus.resp_ready = 1'b0;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    model_ptr = 0;
    model_cnt = 0;
    for (int i = 0; i < NREQ; i++) sb_x[i].delete();
    sb_id.delete();
    got_id.delete();
    got_y.delete();
    acc_log.delete();
    prev_hold = 1'b0;
    prev_wait = '0;
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_issue_cnt", bus.issue_cnt, 0);
    check("rst_rr_ptr", dut.rr_ptr_reg, 0);
    check("rst_resp_data", {bus.resp_y, bus.resp_id, bus.resp_ovf, bus.resp_udf}, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fp32_t xs4 [4];
    fp32_t ys4 [4];
    xs4 = '{FP_ONE, 32'h40800000, 32'h3E800000, 32'h41000000};
    ys4 = '{32'h3F800000, 32'h3E800000, 32'h40800000, 32'h3E000000};
    bus.req_x = '0;

    // Single request and its two-edge latency
    do_reset();
    bus.resp_ready    = 1'b1;
    bus.req_x[31:0]   = 32'h40000000;
    bus.req_valid     = 4'b0001;
    cycle();
    check("lat_edge1_valid", bus.resp_valid, 0);
    cycle();
    check("lat_edge2_valid", bus.resp_valid, 1);
    check("single_y", bus.resp_y, 32'h3F000000);
    check("single_id", bus.resp_id, 0);
    check("single_flags", {bus.resp_ovf, bus.resp_udf}, 0);
    cycle();

    // All four at once: in-order ids on consecutive cycles
    do_reset();
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) bus.req_x[32*i +: 32] = xs4[i];
    bus.req_valid = 4'hF;
    for (int c = 0; c < 4; c++) cycle();
    cycle();
    check("all4_consecutive", bus.resp_valid, 1);
    for (int c = 0; c < 2; c++) cycle();
    check("all4_count", got_id.size(), 4);
    for (int i = 0; i < 4 && i < got_id.size(); i++) begin
      check("all4_id", got_id[i], i);
      check("all4_y", got_y[i], ys4[i]);
    end
    check("all4_rr_ptr", dut.rr_ptr_reg, 0);

    // Backpressure with three pending
    do_reset();
    for (int i = 0; i < 3; i++) bus.req_x[32*i +: 32] = rand_x();
    bus.req_valid = 4'b0111;
    for (int c = 0; c < 7; c++) cycle();
    check("bp_held_ready", bus.req_ready, 0);
    bus.resp_ready = 1'b1;
    for (int c = 0; c < 6; c++) cycle();
    check("bp_count", got_id.size(), 3);
    for (int i = 0; i < 3 && i < got_id.size(); i++) check("bp_order", got_id[i], i);
    check("bp_drained", sb_id.size(), 0);

    // Fairness between requesters 1 and 3
    do_reset();
    bus.resp_ready = 1'b1;
    for (int c = 0; c < 40 && acc_log.size() < 10; c++) begin
      for (int i = 1; i < 4; i += 2) begin
        if (!bus.req_valid[i]) begin
          bus.req_x[32*i +: 32] = rand_x();
          bus.req_valid[i] = 1'b1;
        end
      end
      cycle();
    end
    bus.req_valid = '0;
    for (int c = 0; c < 4; c++) cycle();
    check("fair_count", acc_log.size(), 10);
    for (int k = 0; k < acc_log.size(); k++) check("fair_seq", acc_log[k], (k % 2 == 0) ? 1 : 3);
    check("fair_issue_cnt", bus.issue_cnt, 10);

    // Reset with both stages occupied
    do_reset();
    bus.resp_ready = 1'b1;
    bus.req_x[31:0]  = 32'h40400000;
    bus.req_x[63:32] = 32'h40A00000;
    bus.req_valid = 4'b0011;
    cycle();
    cycle();
    check("mid_full", {bus.resp_valid, dut.s1_valid_reg}, 2'b11);
    do_reset();
    for (int c = 0; c < 4; c++) begin
      cycle();
      check("no_stale", bus.resp_valid, 0);
    end

    // Random traffic
    do_reset();
    for (int c = 0; c < 60000 && model_cnt < 10000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_valid[i]) begin
          if ($urandom_range(0, 1) == 0) begin
            bus.req_x[32*i +: 32] = rand_x();
            bus.req_valid[i] = 1'b1;
          end
        end else if ($urandom_range(0, 49) == 0) begin
          bus.req_valid[i] = 1'b0;
        end
      end
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    check("rand_done", model_cnt >= 10000, 1);
    bus.req_valid  = '0;
    bus.resp_ready = 1'b1;
    for (int c = 0; c < 5; c++) cycle();
    check("rand_drained", sb_id.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
